// File: rtl/tilelink_pkg.sv
// TileLink-UL A/D channel payloads shared by the pinwheel data-side bus.
package tilelink_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [3:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [1:0]  d_size;
        logic [3:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tilelink_d;

endpackage

// File: rtl/tlarb_pkg.sv
// Arbiter-local state encoding and TileLink opcode/timeout constants.
package tlarb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} tlarb_state_e;

    localparam logic [2:0]  TL_OP_GET             = 3'd4;
    localparam logic [2:0]  TL_OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0]  TL_OP_ACCESS_ACK_DATA = 3'd1;
    localparam logic [31:0] TLARB_TIMEOUT_DATA    = 32'hDEADBEEF;

endpackage

// File: rtl/tlarb_rr_pick.sv
// Two-way request picker: sole requester wins, ties go to m0 when fixed,
// otherwise to the master that did not win last.
module tlarb_rr_pick (
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       fixed,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (fixed || rr_last) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/tilelink_arbiter.sv
// Two-master TileLink-UL arbiter, one transaction in flight, A registered to slave.
// Define TILELINK_ARBITER_TIMEOUT_EN to add the RESP watchdog (error D after TIMEOUT_CYCLES).
module tilelink_arbiter
    import tilelink_pkg::*;
    import tlarb_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic      clock,
    input  logic      reset_in,
    input  tilelink_a m0_tla,
    output logic      m0_a_ready,
    output tilelink_d m0_tld,
    input  tilelink_a m1_tla,
    output logic      m1_a_ready,
    output tilelink_d m1_tld,
    output tilelink_a s_tla,
    input  logic      s_a_ready,
    input  tilelink_d s_tld,
    output logic      busy,
    output logic      err_stray
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    tlarb_state_e state_q, state_d;
    tilelink_a    s_tla_q;
    tilelink_d    d_fwd;
    logic         rr_last_q, owner_q, err_stray_q, d_fire;
    logic [1:0]   req, grant;

    assign req = {m1_tla.a_valid, m0_tla.a_valid};

    tlarb_rr_pick u_pick (
        .req     (req),
        .rr_last (rr_last_q),
        .fixed   (FIXED_PRIORITY != 0),
        .grant   (grant)
    );

`ifdef TILELINK_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_q;

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in)
            to_cnt_q <= '0;
        else if (state_q == REQ && s_a_ready)
            to_cnt_q <= '0;
        else if (state_q == RESP)
            to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
`endif

    always_comb begin
        state_d = state_q;
        d_fwd   = s_tld;
        d_fire  = 1'b0;
        case (state_q)
            IDLE: if (|req) state_d = REQ;
            REQ:  if (s_a_ready) state_d = RESP;
            RESP: begin
                if (s_tld.d_valid) begin
                    d_fire  = 1'b1;
                    state_d = IDLE;
                end
`ifdef TILELINK_ARBITER_TIMEOUT_EN
                // A real response in the expiry cycle takes precedence
                else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    d_fire         = 1'b1;
                    state_d        = IDLE;
                    d_fwd          = '0;
                    d_fwd.d_valid  = 1'b1;
                    d_fwd.d_error  = 1'b1;
                    d_fwd.d_data   = TLARB_TIMEOUT_DATA;
                    d_fwd.d_opcode = (s_tla_q.a_opcode == TL_OP_GET) ? TL_OP_ACCESS_ACK_DATA
                                                                     : TL_OP_ACCESS_ACK;
                    d_fwd.d_source = s_tla_q.a_source;
                    d_fwd.d_size   = s_tla_q.a_size;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            owner_q     <= 1'b0;
            s_tla_q     <= '0;
            err_stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (s_tld.d_valid && state_q != RESP)
                err_stray_q <= 1'b1;
            case (state_q)
                IDLE: if (|req) begin
                    s_tla_q   <= grant[1] ? m1_tla : m0_tla;
                    owner_q   <= grant[1];
                    rr_last_q <= grant[1];
                end
                // Payload is kept through RESP so the watchdog can echo source/size
                REQ: if (s_a_ready) s_tla_q.a_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign m0_a_ready = (state_q == IDLE) && grant[0];
    assign m1_a_ready = (state_q == IDLE) && grant[1];
    assign m0_tld     = (d_fire && !owner_q) ? d_fwd : '0;
    assign m1_tld     = (d_fire &&  owner_q) ? d_fwd : '0;
    assign s_tla      = s_tla_q;
    assign busy       = (state_q != IDLE);
    assign err_stray  = err_stray_q;
endmodule

// File: tb/tb_tilelink_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven in lockstep.
module tb_tilelink_arbiter;
    import tilelink_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic      reset_in, s_a_ready;
    tilelink_a m0_tla, m1_tla;
    tilelink_d s_tld;

    logic      rr_m0_ar, rr_m1_ar, rr_busy, rr_err;
    tilelink_d rr_m0_tld, rr_m1_tld;
    tilelink_a rr_s_tla;
    logic      fp_m0_ar, fp_m1_ar, fp_busy, fp_err;
    tilelink_d fp_m0_tld, fp_m1_tld;
    tilelink_a fp_s_tla;

    int checks = 0;
    int errors = 0;

    tilelink_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(4)) u_rr (
        .clock(clock), .reset_in(reset_in),
        .m0_tla(m0_tla), .m0_a_ready(rr_m0_ar), .m0_tld(rr_m0_tld),
        .m1_tla(m1_tla), .m1_a_ready(rr_m1_ar), .m1_tld(rr_m1_tld),
        .s_tla(rr_s_tla), .s_a_ready(s_a_ready), .s_tld(s_tld),
        .busy(rr_busy), .err_stray(rr_err)
    );

    tilelink_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(4)) u_fp (
        .clock(clock), .reset_in(reset_in),
        .m0_tla(m0_tla), .m0_a_ready(fp_m0_ar), .m0_tld(fp_m0_tld),
        .m1_tla(m1_tla), .m1_a_ready(fp_m1_ar), .m1_tld(fp_m1_tld),
        .s_tla(fp_s_tla), .s_a_ready(s_a_ready), .s_tld(s_tld),
        .busy(fp_busy), .err_stray(fp_err)
    );

    function automatic tilelink_a mk_a(logic [2:0] op, logic [3:0] src, logic [31:0] addr,
                                       logic [31:0] data);
        tilelink_a a;
        a = '0;
        a.a_valid = 1'b1; a.a_opcode = op; a.a_size = 2'd2; a.a_source = src;
        a.a_address = addr; a.a_mask = 4'hF; a.a_data = data;
        return a;
    endfunction

    function automatic tilelink_d mk_d(logic [2:0] op, logic [3:0] src, logic [31:0] data);
        tilelink_d d;
        d = '0;
        d.d_valid = 1'b1; d.d_opcode = op; d.d_size = 2'd2; d.d_source = src; d.d_data = data;
        return d;
    endfunction

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_in = 1'b1; m0_tla = '0; m1_tla = '0; s_tld = '0; s_a_ready = 1'b0;
        step(); step();
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        checks++; if (rr_busy !== 1'b0 || rr_err !== 1'b0) begin errors++;
            $display("FAIL reset_busy_err: busy=%b err=%b want 0 0", rr_busy, rr_err); end
        checks++; if (rr_s_tla !== '0) begin errors++;
            $display("FAIL reset_s_tla: got %h want 0", rr_s_tla); end
        checks++; if (rr_m0_ar !== 1'b0 || rr_m1_ar !== 1'b0) begin errors++;
            $display("FAIL reset_a_ready: got %b%b want 00", rr_m1_ar, rr_m0_ar); end
        checks++; if (rr_m0_tld !== '0 || rr_m1_tld !== '0) begin errors++;
            $display("FAIL reset_tld: m0=%h m1=%h want 0", rr_m0_tld, rr_m1_tld); end
    endtask

    task automatic test_single();
        tilelink_a exp_a;
        tilelink_d exp_d;
        int busy_cnt = 0;
        step();
        exp_a = mk_a(3'd4, 4'd1, 32'h80000010, 32'h0);
        m0_tla = exp_a; s_a_ready = 1'b1;
        sample(); busy_cnt += int'(rr_busy);
        checks++; if (rr_m0_ar !== 1'b1 || rr_m1_ar !== 1'b0) begin errors++;
            $display("FAIL single_grant: a_ready m1m0=%b%b want 01", rr_m1_ar, rr_m0_ar); end
        step(); m0_tla = '0;
        sample(); busy_cnt += int'(rr_busy);
        checks++; if (rr_s_tla !== exp_a) begin errors++;
            $display("FAIL single_s_tla: got %h want %h", rr_s_tla, exp_a); end
        step();
        sample(); busy_cnt += int'(rr_busy);
        checks++; if (rr_m0_tld.d_valid !== 1'b0 || rr_s_tla.a_valid !== 1'b0) begin errors++;
            $display("FAIL single_resp_wait: d_valid=%b a_valid=%b want 0 0",
                     rr_m0_tld.d_valid, rr_s_tla.a_valid); end
        step();
        exp_d = mk_d(3'd1, 4'd1, 32'h12345678);
        s_tld = exp_d;
        sample(); busy_cnt += int'(rr_busy);
        checks++; if (rr_m0_tld !== exp_d) begin errors++;
            $display("FAIL single_d_fwd: got %h want %h", rr_m0_tld, exp_d); end
        checks++; if (rr_m1_tld !== '0) begin errors++;
            $display("FAIL single_d_other: got %h want 0", rr_m1_tld); end
        step(); s_tld = '0;
        sample(); busy_cnt += int'(rr_busy);
        checks++; if (busy_cnt !== 3) begin errors++;
            $display("FAIL single_busy_cycles: got %0d want 3", busy_cnt); end
    endtask

    task automatic test_alternate();
        int rr_d0 = 0, rr_d1 = 0, fp_d0 = 0, fp_d1 = 0;
        logic exp0;
        do_reset();
        step();
        m0_tla = mk_a(3'd4, 4'd0, 32'h1000, 32'h0);
        m1_tla = mk_a(3'd0, 4'd1, 32'h2000, 32'hA5);
        s_a_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp0 = (k % 2 == 0);
            sample();
            checks++; if (rr_m0_ar !== exp0 || rr_m1_ar !== !exp0) begin errors++;
                $display("FAIL rr_grant%0d: m1m0=%b%b want %b%b", k, rr_m1_ar, rr_m0_ar, !exp0, exp0); end
            checks++; if (fp_m0_ar !== 1'b1 || fp_m1_ar !== 1'b0) begin errors++;
                $display("FAIL fp_grant%0d: m1m0=%b%b want 01", k, fp_m1_ar, fp_m0_ar); end
            step();
            sample();
            checks++; if (rr_s_tla.a_address !== (exp0 ? 32'h1000 : 32'h2000)) begin errors++;
                $display("FAIL rr_addr%0d: got %h want %h", k, rr_s_tla.a_address,
                         exp0 ? 32'h1000 : 32'h2000); end
            checks++; if (rr_m0_ar | rr_m1_ar | fp_m0_ar | fp_m1_ar) begin errors++;
                $display("FAIL req_no_ready%0d: rr=%b%b fp=%b%b want 0", k,
                         rr_m1_ar, rr_m0_ar, fp_m1_ar, fp_m0_ar); end
            step(); s_tld = mk_d(3'd1, 4'd0, 32'h100 + k);
            sample();
            rr_d0 += int'(rr_m0_tld.d_valid); rr_d1 += int'(rr_m1_tld.d_valid);
            fp_d0 += int'(fp_m0_tld.d_valid); fp_d1 += int'(fp_m1_tld.d_valid);
            checks++; if (fp_m1_ar !== 1'b0) begin errors++;
                $display("FAIL fp_m1_ready%0d: got %b want 0", k, fp_m1_ar); end
            step(); s_tld = '0;
        end
        m0_tla = '0; m1_tla = '0;
        checks++; if (rr_d0 !== 2 || rr_d1 !== 2) begin errors++;
            $display("FAIL rr_d_count: m0=%0d m1=%0d want 2 2", rr_d0, rr_d1); end
        checks++; if (fp_d0 !== 4 || fp_d1 !== 0) begin errors++;
            $display("FAIL fp_d_count: m0=%0d m1=%0d want 4 0", fp_d0, fp_d1); end
        checks++; if (rr_err !== 1'b0 || fp_err !== 1'b0) begin errors++;
            $display("FAIL alt_err: rr=%b fp=%b want 0 0", rr_err, fp_err); end
    endtask

    task automatic test_stall();
        tilelink_a exp_a;
        step();
        exp_a = mk_a(3'd0, 4'd3, 32'h3000, 32'hCAFEF00D);
        m1_tla = exp_a; s_a_ready = 1'b0;
        sample();
        checks++; if (rr_m1_ar !== 1'b1) begin errors++;
            $display("FAIL stall_grant: got %b want 1", rr_m1_ar); end
        step(); m1_tla = '0;
        for (int i = 0; i < 5; i++) begin
            sample();
            checks++; if (rr_s_tla !== exp_a || rr_busy !== 1'b1) begin errors++;
                $display("FAIL stall_hold%0d: s_tla=%h busy=%b want %h 1", i, rr_s_tla, rr_busy, exp_a); end
            checks++; if (rr_m0_ar | rr_m1_ar) begin errors++;
                $display("FAIL stall_ready%0d: m1m0=%b%b want 00", i, rr_m1_ar, rr_m0_ar); end
            step();
        end
        s_a_ready = 1'b1;
        step();
        s_tld = mk_d(3'd0, 4'd3, 32'h0);
        sample();
        checks++; if (rr_m1_tld.d_valid !== 1'b1 || rr_m0_tld !== '0) begin errors++;
            $display("FAIL stall_d: m1 d_valid=%b m0=%h want 1 0", rr_m1_tld.d_valid, rr_m0_tld); end
        step(); s_tld = '0;
    endtask

    task automatic test_reset_mid();
        step();
        m0_tla = mk_a(3'd4, 4'd2, 32'h80000020, 32'h0); s_a_ready = 1'b1;
        sample(); step(); m0_tla = '0;
        sample(); step();
        sample();
        checks++; if (rr_busy !== 1'b1) begin errors++;
            $display("FAIL mid_in_resp: busy=%b want 1", rr_busy); end
        reset_in = 1'b1; #1;
        checks++; if (rr_busy !== 1'b0 || rr_s_tla !== '0) begin errors++;
            $display("FAIL mid_async: busy=%b s_tla=%h want 0 0", rr_busy, rr_s_tla); end
        step(); reset_in = 1'b0;
        s_tld = mk_d(3'd1, 4'd2, 32'h55AA55AA);
        sample();
        checks++; if (rr_m0_tld.d_valid !== 1'b0 || rr_m1_tld.d_valid !== 1'b0) begin errors++;
            $display("FAIL mid_no_fwd: m0=%b m1=%b want 0 0", rr_m0_tld.d_valid, rr_m1_tld.d_valid); end
        step(); s_tld = '0;
        sample();
        checks++; if (rr_err !== 1'b1 || fp_err !== 1'b1 || rr_busy !== 1'b0) begin errors++;
            $display("FAIL mid_stray: rr_err=%b fp_err=%b busy=%b want 1 1 0", rr_err, fp_err, rr_busy); end
        step(); sample();
        checks++; if (rr_err !== 1'b1) begin errors++;
            $display("FAIL mid_sticky: err=%b want 1", rr_err); end
    endtask

`ifdef TILELINK_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        step();
        m1_tla = mk_a(3'd4, 4'd5, 32'h4000, 32'h0); s_a_ready = 1'b1;
        sample(); step(); m1_tla = '0;
        sample(); step();
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++; if (rr_m1_tld.d_valid !== 1'b0) begin errors++;
                $display("FAIL to_early%0d: d_valid=%b want 0", i, rr_m1_tld.d_valid); end
            step();
        end
        sample();
        checks++; if (rr_m1_tld.d_valid !== 1'b1 || rr_m1_tld.d_error !== 1'b1 ||
                      rr_m1_tld.d_opcode !== 3'd1 || rr_m1_tld.d_data !== 32'hDEADBEEF ||
                      rr_m1_tld.d_source !== 4'd5 || rr_m1_tld.d_size !== 2'd2) begin errors++;
            $display("FAIL to_fire: got %h want v=1 op=1 src=5 sz=2 err=1 data=deadbeef", rr_m1_tld); end
        checks++; if (rr_m0_tld !== '0) begin errors++;
            $display("FAIL to_other: got %h want 0", rr_m0_tld); end
        step(); sample();
        checks++; if (rr_busy !== 1'b0 || rr_err !== 1'b0) begin errors++;
            $display("FAIL to_idle: busy=%b err=%b want 0 0", rr_busy, rr_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_reset_mid();
`ifdef TILELINK_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
